fp_round_pipe: RTL

//  Pipelined rounding/packing stage downstream of fp_mul: consumes uround_res_t (unrounded result, R/S bits, round_en,

---
 rtl/fp_round_pipe_if.sv | 26 ++
 rtl/fp_round_pipe.sv | 98 +++++++++
 2 files changed

// File: rtl/fp_round_pipe_if.sv
// fp_round_pipe_if: upstream uround_res_t beat and downstream rounded-result beat for fp_round_pipe.
// FP_FORMAT: 0 = FP32, 1 = FP64, 2 = FP16.
interface fp_round_pipe_if #(parameter int unsigned FP_FORMAT = 0);
   localparam int unsigned EXP_WIDTH  = FP_FORMAT == 1 ? 11 : FP_FORMAT == 2 ? 5 : 8;
   localparam int unsigned MANT_WIDTH = FP_FORMAT == 1 ? 52 : FP_FORMAT == 2 ? 10 : 23;
   localparam int unsigned FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;
   typedef struct packed {
      logic [FP_WIDTH-1:0] u_result;
      logic [1:0]          rs;
      logic                round_en;
      logic                invalid;
      logic [1:0]          exp_cout;
   } uround_res_t;
   uround_res_t         urnd_result_i;
   logic [2:0]          rnd_mode_i;
   logic                valid_i;
   logic                ready_o;
   logic [FP_WIDTH-1:0] result_o;
   logic [4:0]          fflags_o;
   logic                valid_o;
   logic                ready_i;
   modport master (output urnd_result_i, rnd_mode_i, valid_i, ready_i,
                   input  ready_o, result_o, fflags_o, valid_o);
   modport slave  (input  urnd_result_i, rnd_mode_i, valid_i, ready_i,
                   output ready_o, result_o, fflags_o, valid_o);
endinterface

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage elastic rounding/packing of uround_res_t into an IEEE-754 result plus fflags.
// Optional FP_ROUND_STICKY_FLAGS_EN adds clr_flags_i / fflags_acc_o sticky flag accumulator.
module fp_round_pipe #(
   parameter int unsigned FP_FORMAT = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
`ifdef FP_ROUND_STICKY_FLAGS_EN
   input  logic       clr_flags_i,
   output logic [4:0] fflags_acc_o,
`endif
   fp_round_pipe_if.slave bus
);
   localparam int unsigned EW = FP_FORMAT == 1 ? 11 : FP_FORMAT == 2 ? 5 : 8;
   localparam int unsigned MW = FP_FORMAT == 1 ? 52 : FP_FORMAT == 2 ? 10 : 23;
   localparam int unsigned W  = 1 + EW + MW;

   logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic          adv2, ld1, ld2;
   logic [W-1:0]  u1_q;
   logic [1:0]    rs1_q, cout1_q;
   logic          en1_q, inv1_q;
   logic [2:0]    rm1_q;
   logic [W-1:0]  res_q, res_d;
   logic [4:0]    flg_q, flg_d;
   logic          sign, rne, inc, inexact, of, uf, to_inf;
   logic [EW+MW-1:0] sum, near;

   assign adv2        = !s2_valid_q | bus.ready_i;
   assign bus.ready_o = !s1_valid_q | adv2;
   assign ld1         = bus.valid_i & bus.ready_o;
   assign ld2         = s1_valid_q & adv2;
   assign s1_valid_d  = ld1 | (s1_valid_q & !adv2);
   assign s2_valid_d  = adv2 ? s1_valid_q : s2_valid_q;

   // Overflow is also judged on the round-to-nearest magnitude, so truncating modes still flag OF.
   always_comb begin
      sign    = u1_q[W-1];
      rne     = rm1_q == 3'b000 || rm1_q > 3'b100;
      inexact = |rs1_q;
      inc     = rne            ? rs1_q[1] & (rs1_q[0] | u1_q[0]) :
                rm1_q == 3'b010 ? sign & inexact :
                rm1_q == 3'b011 ? !sign & inexact :
                rm1_q == 3'b100 ? rs1_q[1] : 1'b0;
      sum     = u1_q[W-2:0] + {{(EW+MW-1){1'b0}}, inc};
      near    = u1_q[W-2:0] + {{(EW+MW-1){1'b0}}, rs1_q[1]};
      of      = cout1_q == 2'b01 || &u1_q[W-2:MW] || &sum[EW+MW-1:MW] || &near[EW+MW-1:MW];
      uf      = cout1_q[1] || ~|u1_q[W-2:MW];
      to_inf  = rne || rm1_q == 3'b100 || (rm1_q == 3'b010 && sign) || (rm1_q == 3'b011 && !sign);
      res_d   = !en1_q ? u1_q :
                of     ? (to_inf ? {sign, {EW{1'b1}}, {MW{1'b0}}} : {sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}}) :
                uf     ? {sign, {(W-1){1'b0}}} : {sign, sum};
      flg_d   = {inv1_q, 1'b0, en1_q & of, en1_q & !of & uf, en1_q & (of | uf | inexact)};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         u1_q       <= '0;
         rs1_q      <= '0;
         cout1_q    <= '0;
         en1_q      <= 1'b0;
         inv1_q     <= 1'b0;
         rm1_q      <= '0;
         res_q      <= '0;
         flg_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (ld1) begin
            u1_q    <= bus.urnd_result_i.u_result;
            rs1_q   <= bus.urnd_result_i.rs;
            cout1_q <= bus.urnd_result_i.exp_cout;
            en1_q   <= bus.urnd_result_i.round_en;
            inv1_q  <= bus.urnd_result_i.invalid;
            rm1_q   <= bus.rnd_mode_i;
         end
         if (ld2) begin
            res_q <= res_d;
            flg_q <= flg_d;
         end
      end
   end

   assign bus.valid_o  = s2_valid_q;
   assign bus.result_o = res_q;
   assign bus.fflags_o = flg_q;

`ifdef FP_ROUND_STICKY_FLAGS_EN
   logic [4:0] acc_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= '0;
      else         acc_q <= clr_flags_i ? '0 : acc_q | ({5{bus.valid_o & bus.ready_i}} & flg_q);
   end
   assign fflags_acc_o = acc_q;
`endif
endmodule
